// File: rtl/sprite_renderer_pkg.sv
// Shared constants, state and sprite-select encodings for the sprite renderer.
package sprite_renderer_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned PLAYER_W = 3;

  localparam logic [2:0] BG_COLOUR     = 3'b000;
  localparam logic [2:0] PLAYER_COLOUR = 3'b010;
  localparam logic [2:0] ENEMY_COLOUR  = 3'b100;
  localparam logic [2:0] BULLET_COLOUR = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_ERASE,
    ST_DRAW,
    ST_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    SEL_PLAYER = 2'd0,
    SEL_ENEMY  = 2'd1,
    SEL_BULLET = 2'd2
  } sprite_sel_t;

  function automatic logic [2:0] sprite_colour(input sprite_sel_t sel);
    logic [2:0] c;
    c = PLAYER_COLOUR;
    case (sel)
      SEL_ENEMY:  c = ENEMY_COLOUR;
      SEL_BULLET: c = BULLET_COLOUR;
      default:    c = PLAYER_COLOUR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Sprite controller inputs and VGA adapter write port of the renderer.
interface sprite_renderer_if;
  logic       clear_req;
  logic       player_move;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic       enemy_move;
  logic [7:0] enemy_x;
  logic [6:0] enemy_y;
  logic [2:0] enemy_width;
  logic       bullet_move;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       clear_done;

  modport master (
    output clear_req, player_move, player_x, player_y,
           enemy_move, enemy_x, enemy_y, enemy_width,
           bullet_move, bullet_x, bullet_y,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, clear_done
  );

  modport slave (
    input  clear_req, player_move, player_x, player_y,
           enemy_move, enemy_x, enemy_y, enemy_width,
           bullet_move, bullet_x, bullet_y,
    output vga_x, vga_y, vga_colour, vga_plot, busy, clear_done
  );
endinterface

// File: rtl/sprite_renderer_square_scanner.sv
// Row-major pixel walker over a square (or the whole screen in full mode).
// Coordinates and plot are registered: start loads the origin pixel on the
// same edge, each advance steps to the next pixel, last flags the final one.
module square_scanner
  import sprite_renderer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  input  logic       full,
  input  logic [7:0] org_x,
  input  logic [6:0] org_y,
  input  logic [2:0] side,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic       plot,
  output logic       last
);

  logic [8:0] cur_x, nxt_x, base_x;
  logic [7:0] cur_y, nxt_y;
  logic [7:0] dx, w_r;
  logic [6:0] dy, h_r;
  logic       row_end;

  assign row_end = (dx == w_r - 8'd1);
  assign last    = row_end && (dy == h_r - 7'd1);
  assign pix_x   = cur_x[7:0];
  assign pix_y   = cur_y[6:0];

  // Next pixel coordinate, 9/8-bit wide so off-screen pixels never wrap
  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    if (start) begin
      nxt_x = full ? '0 : {1'b0, org_x};
      nxt_y = full ? '0 : {1'b0, org_y};
    end else if (advance) begin
      if (row_end) begin
        nxt_x = base_x;
        nxt_y = cur_y + 8'd1;
      end else begin
        nxt_x = cur_x + 9'd1;
      end
    end
  end

  // Walker state and registered pixel output
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x  <= '0;
      cur_y  <= '0;
      base_x <= '0;
      dx     <= '0;
      dy     <= '0;
      w_r    <= 8'd1;
      h_r    <= 7'd1;
      plot   <= 1'b0;
    end else begin
      cur_x <= nxt_x;
      cur_y <= nxt_y;
      plot  <= (start || advance) && (nxt_x < 9'(SCREEN_W)) && (nxt_y < 8'(SCREEN_H));
      if (start) begin
        dx     <= '0;
        dy     <= '0;
        base_x <= full ? '0 : {1'b0, org_x};
        w_r    <= full ? 8'(SCREEN_W) : {5'b0, side};
        h_r    <= full ? 7'(SCREEN_H) : {4'b0, side};
      end else if (advance) begin
        if (row_end) begin
          dx <= '0;
          dy <= dy + 7'd1;
        end else begin
          dx <= dx + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_renderer.sv
// Erases and redraws player/enemy/bullet squares and clears the screen,
// one registered pixel per clock, on the VGA adapter write port.
module sprite_renderer
  import sprite_renderer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  sprite_renderer_if.slave   bus
);

  state_t      state, state_n;
  sprite_sel_t sel, sel_n;
  logic [2:0]  colour_r, colour_n;

  logic       pend_clear;
  logic [2:0] pend, drawn, snap_mask, move_vec;
  logic [7:0] old_x [3];
  logic [6:0] old_y [3];
  logic [2:0] old_w [3];
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] new_w;
  logic       clear_done_r;

  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_w;

  logic       sc_start, sc_adv, sc_full, sc_plot, sc_last;
  logic [7:0] sc_x, sc_px;
  logic [6:0] sc_y, sc_py;
  logic [2:0] sc_w;

  logic       snap_take, finish, clear_fin, take_clear;
  logic [7:0] fin_x;
  logic [6:0] fin_y;
  logic [2:0] fin_w;

  square_scanner u_scan (
    .clk     (clk),
    .reset   (reset),
    .start   (sc_start),
    .advance (sc_adv),
    .full    (sc_full),
    .org_x   (sc_x),
    .org_y   (sc_y),
    .side    (sc_w),
    .pix_x   (sc_px),
    .pix_y   (sc_py),
    .plot    (sc_plot),
    .last    (sc_last)
  );

  assign bus.vga_x      = sc_px;
  assign bus.vga_y      = sc_py;
  assign bus.vga_plot   = sc_plot;
  assign bus.vga_colour = colour_r;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.clear_done = clear_done_r;

  assign move_vec  = {bus.bullet_move, bus.enemy_move, bus.player_move};
  assign snap_mask = snap_take ? (3'b001 << sel) : 3'b000;

  // Live position/width of the selected sprite
  always_comb begin
    in_x = bus.player_x;
    in_y = bus.player_y;
    in_w = 3'(PLAYER_W);
    case (sel)
      SEL_ENEMY: begin
        in_x = bus.enemy_x;
        in_y = bus.enemy_y;
        in_w = bus.enemy_width;
      end
      SEL_BULLET: begin
        in_x = bus.bullet_x;
        in_y = bus.bullet_y;
        in_w = 3'd1;
      end
      default: ;
    endcase
  end

  // Next state, scanner control and colour of the next emitted pixel.
  // The state names the phase of the pixel currently on the output, so phase
  // changes restart the scanner on the edge that retires the last pixel.
  always_comb begin
    state_n    = state;
    sel_n      = sel;
    colour_n   = colour_r;
    sc_start   = 1'b0;
    sc_adv     = 1'b0;
    sc_full    = 1'b0;
    sc_x       = new_x;
    sc_y       = new_y;
    sc_w       = new_w;
    snap_take  = 1'b0;
    finish     = 1'b0;
    clear_fin  = 1'b0;
    take_clear = 1'b0;
    fin_x      = new_x;
    fin_y      = new_y;
    fin_w      = new_w;
    unique case (state)
      ST_IDLE: begin
        if (pend_clear) begin
          take_clear = 1'b1;
          sc_start   = 1'b1;
          sc_full    = 1'b1;
          colour_n   = BG_COLOUR;
          state_n    = ST_CLEAR;
        end else if (pend[0]) begin
          sel_n   = SEL_PLAYER;
          state_n = ST_SNAP;
        end else if (pend[1]) begin
          sel_n   = SEL_ENEMY;
          state_n = ST_SNAP;
        end else if (pend[2]) begin
          sel_n   = SEL_BULLET;
          state_n = ST_SNAP;
        end
      end
      ST_SNAP: begin
        snap_take = 1'b1;
        if (drawn[sel] && (old_w[sel] != '0)) begin
          sc_start = 1'b1;
          sc_x     = old_x[sel];
          sc_y     = old_y[sel];
          sc_w     = old_w[sel];
          colour_n = BG_COLOUR;
          state_n  = ST_ERASE;
        end else if (in_w != '0) begin
          sc_start = 1'b1;
          sc_x     = in_x;
          sc_y     = in_y;
          sc_w     = in_w;
          colour_n = sprite_colour(sel);
          state_n  = ST_DRAW;
        end else begin
          // zero-width sprite with nothing to erase: record it and return
          finish  = 1'b1;
          fin_x   = in_x;
          fin_y   = in_y;
          fin_w   = in_w;
          state_n = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (!sc_last) begin
          sc_adv = 1'b1;
        end else if (new_w != '0) begin
          sc_start = 1'b1;
          colour_n = sprite_colour(sel);
          state_n  = ST_DRAW;
        end else begin
          finish  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (!sc_last) begin
          sc_adv = 1'b1;
        end else begin
          finish  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (!sc_last) begin
          sc_adv = 1'b1;
        end else begin
          clear_fin = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state, selected sprite and output colour registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sel      <= SEL_PLAYER;
      colour_r <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      colour_r <= colour_n;
    end
  end

  // Pending flags: new pulses win over the clear of the sprite being serviced
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_clear   <= 1'b0;
      pend         <= '0;
      clear_done_r <= 1'b0;
    end else begin
      pend_clear   <= (pend_clear & ~take_clear) | bus.clear_req;
      pend         <= (pend & ~snap_mask) | move_vec | {3{clear_fin}};
      clear_done_r <= clear_fin;
    end
  end

  // Working (new) square, last-drawn square per sprite and drawn flags
  always_ff @(posedge clk) begin
    if (reset) begin
      new_x <= '0;
      new_y <= '0;
      new_w <= '0;
      drawn <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        old_x[i] <= '0;
        old_y[i] <= '0;
        old_w[i] <= '0;
      end
    end else begin
      if (snap_take) begin
        new_x <= in_x;
        new_y <= in_y;
        new_w <= in_w;
      end
      if (finish) begin
        old_x[sel] <= fin_x;
        old_y[sel] <= fin_y;
        old_w[sel] <= fin_w;
        drawn[sel] <= 1'b1;
      end
      if (clear_fin) begin
        drawn <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed self-checking bench for sprite_renderer.
module tb_sprite_renderer;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct packed {
    logic p;
    pix_t px;
  } raw_t;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  int   n_busy;
  int   n_done;
  pix_t mon_q[$];
  pix_t exp_q[$];
  raw_t raw_q[$];

  sprite_renderer_if bus();

  sprite_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every plotted pixel and every busy cycle
  always @(negedge clk) begin
    pix_t p;
    raw_t r;
    p.x = {1'b0, bus.vga_x};
    p.y = {1'b0, bus.vga_y};
    p.c = bus.vga_colour;
    if (bus.vga_plot === 1'b1) mon_q.push_back(p);
    if (bus.busy === 1'b1) begin
      n_busy++;
      r.p  = bus.vga_plot;
      r.px = p;
      raw_q.push_back(r);
    end
    if (bus.clear_done === 1'b1) n_done++;
  end

  task automatic clear_logs();
    mon_q.delete();
    exp_q.delete();
    raw_q.delete();
    n_busy = 0;
    n_done = 0;
  endtask

  task automatic push_sq(input int x0, input int y0, input int w, input int c);
    pix_t p;
    for (int dy = 0; dy < w; dy++)
      for (int dx = 0; dx < w; dx++) begin
        p.x = 9'(x0 + dx);
        p.y = 8'(y0 + dy);
        p.c = 3'(c);
        exp_q.push_back(p);
      end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      if (mon_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic pulse(input logic c, input logic p, input logic e, input logic b);
    @(posedge clk); #1;
    bus.clear_req   = c;
    bus.player_move = p;
    bus.enemy_move  = e;
    bus.bullet_move = b;
    @(posedge clk); #1;
    bus.clear_req   = 1'b0;
    bus.player_move = 1'b0;
    bus.enemy_move  = 1'b0;
    bus.bullet_move = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) quiet = 0;
      else quiet++;
    end
    checks++;
    if (quiet < 4) begin
      fails++;
      $display("FAIL %s_timeout busy still high after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.vga_x !== 8'd0) begin fails++; $display("FAIL reset_vga_x got %0d want 0", bus.vga_x); end
    checks++; if (bus.vga_y !== 7'd0) begin fails++; $display("FAIL reset_vga_y got %0d want 0", bus.vga_y); end
    checks++; if (bus.vga_colour !== 3'd0) begin fails++; $display("FAIL reset_colour got %0d want 0", bus.vga_colour); end
    checks++; if (bus.vga_plot !== 1'b0) begin fails++; $display("FAIL reset_plot got %b want 0", bus.vga_plot); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.clear_done !== 1'b0) begin fails++; $display("FAIL reset_clear_done got %b want 0", bus.clear_done); end
  endtask

  task automatic check_seq(input string tag, input int want_busy);
    int d;
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_count got %0d plots want %0d", tag, mon_q.size(), exp_q.size());
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      fails++;
      $display("FAIL %s_seq idx %0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", tag, d,
               mon_q[d].x, mon_q[d].y, mon_q[d].c, exp_q[d].x, exp_q[d].y, exp_q[d].c);
    end
    if (want_busy >= 0) begin
      checks++;
      if (n_busy != want_busy) begin
        fails++;
        $display("FAIL %s_busy_cycles got %0d want %0d", tag, n_busy, want_busy);
      end
    end
  endtask

  task automatic test_first_draw();
    bus.player_x = 8'd80;
    bus.player_y = 7'd115;
    @(posedge clk); #1 clear_logs();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL lat_k plot=%b busy=%b want 0 0", bus.vga_plot, bus.busy); end
    @(negedge clk);
    checks++; if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL lat_snap plot=%b busy=%b want 0 1", bus.vga_plot, bus.busy); end
    @(negedge clk);
    checks++;
    if (bus.vga_plot !== 1'b1 || bus.vga_x !== 8'd80 || bus.vga_y !== 7'd115 || bus.vga_colour !== 3'b010) begin
      fails++;
      $display("FAIL lat_first plot=%b (%0d,%0d,c%0d) want 1 (80,115,c2)", bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    wait_idle(100, "first_draw");
    push_sq(80, 115, 3, 2);
    check_seq("first_draw", 10);
  endtask

  task automatic test_move_erase();
    bus.player_x = 8'd81;
    @(posedge clk); #1 clear_logs();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle(100, "move_erase");
    push_sq(80, 115, 3, 0);
    push_sq(81, 115, 3, 2);
    check_seq("move_erase", 19);
  endtask

  task automatic test_back_to_back();
    bus.player_x    = 8'd10;
    bus.player_y    = 7'd10;
    bus.enemy_x     = 8'd20;
    bus.enemy_y     = 7'd30;
    bus.enemy_width = 3'd2;
    bus.bullet_x    = 8'd50;
    bus.bullet_y    = 7'd60;
    @(posedge clk); #1 clear_logs();
    pulse(1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle(200, "back_to_back");
    push_sq(81, 115, 3, 0);
    push_sq(10, 10, 3, 2);
    push_sq(20, 30, 2, 4);
    push_sq(50, 60, 1, 7);
    check_seq("back_to_back", 26);
  endtask

  task automatic test_edge_clip();
    bus.enemy_x     = 8'd158;
    bus.enemy_y     = 7'd118;
    bus.enemy_width = 3'd4;
    @(posedge clk); #1 clear_logs();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(100, "edge_clip");
    push_sq(20, 30, 2, 0);
    push_sq(158, 118, 2, 4);
    check_seq("edge_clip", 21);
    checks++;
    if (raw_q.size() < 21 || raw_q[7].p !== 1'b0 || raw_q[7].px.x !== 9'd160) begin
      fails++;
      $display("FAIL edge_clip_x160 raw entries %0d, entry7 plot=%b x=%0d want plot 0 x 160",
               raw_q.size(), raw_q.size() > 7 ? raw_q[7].p : 1'bx, raw_q.size() > 7 ? raw_q[7].px.x : 9'd0);
    end
    checks++;
    if (raw_q.size() < 21 || raw_q[13].p !== 1'b0 || raw_q[13].px.y !== 8'd120) begin
      fails++;
      $display("FAIL edge_clip_y120 raw entries %0d, entry13 plot=%b y=%0d want plot 0 y 120",
               raw_q.size(), raw_q.size() > 13 ? raw_q[13].p : 1'bx, raw_q.size() > 13 ? raw_q[13].px.y : 8'd0);
    end
  endtask

  task automatic test_clear();
    pix_t p;
    logic found;
    bus.enemy_x     = 8'd5;
    bus.enemy_y     = 7'd5;
    bus.enemy_width = 3'd2;
    @(posedge clk); #1 clear_logs();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.vga_plot === 1'b1 && bus.vga_colour === 3'b100) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL clear_enemy_draw_seen got none want enemy draw pixel within 40 cycles");
    end
    bus.clear_req = 1'b1;
    @(posedge clk); #1 bus.clear_req = 1'b0;
    wait_idle(25000, "clear");
    push_sq(158, 118, 2, 0);
    push_sq(5, 5, 2, 4);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        p.x = 9'(x);
        p.y = 8'(y);
        p.c = 3'd0;
        exp_q.push_back(p);
      end
    push_sq(10, 10, 3, 2);
    push_sq(5, 5, 2, 4);
    push_sq(50, 60, 1, 7);
    check_seq("clear", -1);
    checks++;
    if (n_done != 1) begin
      fails++;
      $display("FAIL clear_done_pulses got %0d want 1", n_done);
    end
  endtask

  task automatic test_reset_mid_erase();
    logic found;
    bus.player_x = 8'd30;
    bus.player_y = 7'd30;
    @(posedge clk); #1 clear_logs();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.vga_plot === 1'b1 && bus.vga_colour === 3'b000) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL rst_erase_seen got none want erase pixel within 20 cycles");
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_outputs plot=%b busy=%b want 0 0", bus.vga_plot, bus.busy);
    end
    mon_q.delete();
    repeat (6) @(negedge clk);
    checks++;
    if (mon_q.size() != 0) begin
      fails++;
      $display("FAIL rst_no_plots got %0d plots want 0", mon_q.size());
    end
    @(posedge clk); #1 clear_logs();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle(100, "rst_redraw");
    push_sq(30, 30, 3, 2);
    check_seq("rst_redraw", 10);
  endtask

  initial begin
    checks           = 0;
    fails            = 0;
    n_busy           = 0;
    n_done           = 0;
    reset            = 1'b1;
    bus.clear_req    = 1'b0;
    bus.player_move  = 1'b0;
    bus.player_x     = '0;
    bus.player_y     = '0;
    bus.enemy_move   = 1'b0;
    bus.enemy_x      = '0;
    bus.enemy_y      = '0;
    bus.enemy_width  = '0;
    bus.bullet_move  = 1'b0;
    bus.bullet_x     = '0;
    bus.bullet_y     = '0;
    test_reset();
    test_first_draw();
    test_move_erase();
    test_back_to_back();
    test_edge_clip();
    test_clear();
    test_reset_mid_erase();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Downstream of the player, enemy and bullet controllers; sits between them and the VGA adapter.
- Consumes each controller's one-cycle move pulse and its coordinates.
- For each sprite, erases the previously drawn square in background colour, then draws the square at its new position, one pixel per clock.
- Also performs a full-screen clear on request. Output is the VGA adapter's x/y/colour/plot write port.

Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- PLAYER_W, 3, player square width
- BG_COLOUR, 3'b000, erase/clear colour
- PLAYER_COLOUR, 3'b010, player draw colour
- ENEMY_COLOUR, 3'b100, enemy draw colour
- BULLET_COLOUR, 3'b111, bullet draw colour (bullet is 1x1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  pulse: clear whole screen, then redraw all sprites
- player_move  in  1  pulse: player position changed
- player_x  in  8  player top-left x
- player_y  in  7  player top-left y
- enemy_move  in  1  pulse: enemy position changed
- enemy_x  in  8  enemy top-left x
- enemy_y  in  7  enemy top-left y
- enemy_width  in  3  enemy square width
- bullet_move  in  1  pulse: bullet position changed
- bullet_x  in  8  bullet x
- bullet_y  in  7  bullet y
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write strobe
- busy  out  1  high whenever state is not IDLE
- clear_done  out  1  one-cycle pulse when a clear finishes

Behaviour:
- Reset (synchronous, active-high; one clk edge with reset=1 takes effect):
  - vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, clear_done=0.
  - All pending flags and drawn flags = 0; state = IDLE.
  - Reset mid-operation abandons the current erase/draw immediately; no further plots are issued.
- Pending flags (clear, player, enemy, bullet):
  - A move pulse sets its flag on the same edge.
  - A pulse that arrives while that sprite is being serviced re-sets the flag, so the sprite is serviced again afterwards.
  - Pulses are never lost; multiple pulses before service coalesce into one.
- Arbitration, evaluated in IDLE: clear > player > enemy > bullet.
- FSM: IDLE -> SNAP -> ERASE -> DRAW -> IDLE; IDLE -> CLEAR -> IDLE.
  - SNAP (1 cycle):
    - Latch new x, y and width of the selected sprite into the working registers.
    - Clear its pending flag.
    - If the sprite's drawn flag is 0, go straight to DRAW (skip ERASE).
  - ERASE: iterate over the stored old square (old x, y, width) in row-major order, dx fastest; one pixel per cycle; vga_colour = BG_COLOUR.
  - DRAW: iterate over the new square in the same order, using the sprite colour. On the last pixel:
    - old coordinates/width <= new;
    - drawn flag <= 1;
    - return to IDLE.
  - CLEAR:
    - Iterate x 0..159 within y 0..119 (19200 cycles) in BG_COLOUR.
    - On the last pixel: pulse clear_done for 1 cycle, set drawn flags to 0, set player/enemy/bullet pending flags to 1 so all three are redrawn.
- Output timing:
  - vga_x, vga_y, vga_colour and vga_plot are registered and change together.
  - Latency: pulse sampled at edge k; SNAP occupies k+1..k+2; the first plot is asserted after edge k+2.
- Width and arithmetic rules:
  - Pixel coordinates are computed as 9-bit x and 8-bit y (no wrap).
  - Any pixel with x>=SCREEN_W or y>=SCREEN_H has vga_plot=0 but still consumes its cycle.
- Enemy width 0: ERASE/DRAW emit no pixels and take 0 cycles; drawn flag still updates.
- Cycle counts: player 3x3 with drawn=1 takes 9 erase + 9 draw plot cycles; first draw takes 9.

Decomposition:
- Shared package holds:
  - SCREEN_W/SCREEN_H/PLAYER_W constants (replacing the current `define macros);
  - colour constants;
  - FSM state encoding;
  - sprite-select encoding (PLAYER=0, ENEMY=1, BULLET=2).
- One sub-module, square_scanner: given origin, width and start, emits row-major x/y each cycle plus a done flag. It is reused for ERASE, DRAW and CLEAR; CLEAR uses a separate W×H mode.

Test Plan:
- Reset, then player_move with (80,115): first plot 2 cycles after the pulse edge; 9 plots with colour 3'b010 covering x 80..82, y 115..117; no erase; busy drops after the 9th plot.
- Player then moves to (81,115): 9 plots at x 80..82 in 3'b000, then 9 plots at x 81..83 in 3'b010.
- player_move, enemy_move and bullet_move all in the same cycle: service order is player, enemy, bullet; every pulse is serviced exactly once.
- Enemy of width 4 at (158,118): the pixels at x 160..161 and y 120..121 have plot=0; total DRAW cycles = 16; plot asserted on 4 of them.
- clear_req during an enemy DRAW: the enemy finishes first, then 19200 plots in 3'b000; clear_done pulses for 1 cycle; then all three sprites redraw with no erase phase.
- reset asserted mid-ERASE: the next cycle has vga_plot=0 and busy=0; a later move pulse goes SNAP->DRAW with no erase because the drawn flags are 0.
